// File: rtl/fifo_burst_reader_if.sv
// Bundles the burst command, FIFO read port and output stream of fifo_burst_reader.
// The master modport is the reader's view; slave is the surrounding environment.
interface fifo_burst_reader_if #(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 8
);
    logic              start;
    logic [LWIDTH-1:0] len;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DWIDTH-1:0] fifo_d_out;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;

    modport master (
        input  start, len, fifo_empty, fifo_d_out, m_ready,
        output busy, done, fifo_r_en, m_valid, m_data, m_last
    );

    modport slave (
        output start, len, fifo_empty, fifo_d_out, m_ready,
        input  busy, done, fifo_r_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops exactly len words from a registered-read FIFO and streams them out with a last flag,
// hiding the one-cycle read latency behind a 2-entry in-order skid buffer.
module fifo_burst_reader #(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_l,
    fifo_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [LWIDTH-1:0] issued_q, issued_d;
    logic [LWIDTH-1:0] delivered_q, delivered_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              pop;
    logic              rd_en;
    logic              last_head;
    logic [1:0]        occ;
    logic [1:0]        occ_after_pop;
    logic [1:0]        wr_idx;
    logic [DWIDTH-1:0] ent [2];

    assign pop           = (cnt_q != 2'd0) && bus.m_ready;
    assign occ           = cnt_q + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};
    assign last_head     = (delivered_q == (len_q - LWIDTH'(1)));

    // A read is only launched if its word is guaranteed a slot when it lands next cycle.
    assign rd_en = (state_q == RUN) && !bus.fifo_empty && (issued_q < len_q)
                   && (occ_after_pop < 2'd2);

    assign bus.fifo_r_en = rd_en;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == FIN);
    assign bus.m_valid   = (cnt_q != 2'd0);
    assign bus.m_data    = ent[0];
    assign bus.m_last    = (cnt_q != 2'd0) && last_head;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d       = bus.len;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (bus.len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    issued_d = issued_q + LWIDTH'(1);
                end
                if (pop) begin
                    delivered_d = delivered_q + LWIDTH'(1);
                    if (last_head) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Returned word lands in the first free slot after this cycle's pop has shifted the head.
    always_comb begin
        inflight_d = rd_en;
        cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        wr_idx     = cnt_q - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DWIDTH-1:0] ent_q, ent_d;
            logic [DWIDTH-1:0] shift_src;

            if (gi == 0) begin : g_head
                assign shift_src = ent[1];
            end else begin : g_tail
                assign shift_src = ent_q;
            end

            always_comb begin
                ent_d = ent_q;
                if (pop) begin
                    ent_d = shift_src;
                end
                if (inflight_q && (wr_idx == 2'(gi))) begin
                    ent_d = bus.fifo_d_out;
                end
            end

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    ent_q <= '0;
                end else begin
                    ent_q <= ent_d;
                end
            end

            assign ent[gi] = ent_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-based FIFO, a burst-level reference model
// checked every cycle, and literal expectations for each directed scenario.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DWIDTH(DW), .LWIDTH(LW)) bus ();

    fifo_burst_reader #(.DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- FIFO model: registered empty, data one cycle after r_en
    logic [7:0] fq[$];
    logic [7:0] rdq[$];
    int         rden_cnt = 0;

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_d_out = '0;
    end

    always @(posedge clk) begin
        logic [7:0] w;
        if (bus.fifo_r_en) begin
            rden_cnt++;
            if (fq.size() > 0) w = fq.pop_front();
            else w = 8'hEE;
            bus.fifo_d_out <= w;
            rdq.push_back(w);
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    // ---------------- Burst-level reference model and per-cycle compare
    int         phase = 0;  // 0 idle, 1 streaming, 2 done cycle
    int         cur_len = 0;
    int         acc = 0;
    int         outst = 0;
    int         burst_reads = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         start_cyc = -1;
    int         first_valid_cyc = -1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] beats[$];
    int         beat_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge rst_l) begin
        phase = 0;
        rdq.delete();
        outst = 0;
        acc = 0;
        burst_reads = 0;
        prev_hold = 1'b0;
    end

    always @(negedge clk) begin
        int pop;
        if (rst_l) begin
            pop = (bus.m_valid && bus.m_ready) ? 1 : 0;
            chk("busy", int'(bus.busy), int'(phase == 1));
            chk("done", int'(bus.done), int'(phase == 2));
            if (bus.done) done_cnt++;
            if (bus.fifo_r_en) begin
                chk("ren_while_empty", int'(bus.fifo_empty), 0);
                chk("ren_outside_burst", phase, 1);
                chk("ren_no_room", int'((outst - pop) < 2), 1);
                chk("ren_over_len", int'(burst_reads < cur_len), 1);
                burst_reads++;
            end
            if (prev_hold) begin
                chk("stall_valid", int'(bus.m_valid), 1);
                chk("stall_data", int'(bus.m_data), int'(prev_data));
            end
            if (bus.m_valid) begin
                chk("valid_outside_burst", phase, 1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (rdq.size() == 0) chk("data_available", 0, 1);
                else chk("data", int'(bus.m_data), int'(rdq[0]));
                chk("last", int'(bus.m_last), int'(acc == cur_len - 1));
            end
            if (pop != 0) begin
                $display("beat %0d data=%0d last=%0d", acc, bus.m_data, bus.m_last);
                beats.push_back(bus.m_data);
                beat_cyc.push_back(cyc);
                if (rdq.size() > 0) void'(rdq.pop_front());
                acc++;
            end
            outst = outst + (bus.fifo_r_en ? 1 : 0) - pop;
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            case (phase)
                0: if (bus.start) begin
                    cur_len = int'(bus.len);
                    acc = 0;
                    burst_reads = 0;
                    start_cyc = cyc;
                    phase = (bus.len == 0) ? 2 : 1;
                end
                1: if (pop != 0 && acc == cur_len) phase = 2;
                default: phase = 0;
            endcase
        end
    end

    // ---------------- Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_fifo();
        fq.delete();
        tick();
        tick();
    endtask

    task automatic preload(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'(first + i));
        tick();
        tick();
    endtask

    task automatic clear_stats();
        beats.delete();
        beat_cyc.delete();
        rden_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        start_cyc = -1;
    endtask

    task automatic do_start(input int l);
        tick();
        bus.start = 1'b1;
        bus.len = 8'(l);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic toggle);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (toggle) bus.m_ready = ~bus.m_ready;
            if (done_cnt > d0) break;
        end
        chk("done_within_budget", int'(done_cnt > d0), 1);
    endtask

    task automatic check_beats(input string name, input int first, input int n);
        chk({name, "_count"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) chk({name, "_value"}, int'(beats[i]), first + i);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_done"}, int'(bus.done), 0);
        chk({name, "_r_en"}, int'(bus.fifo_r_en), 0);
        chk({name, "_m_valid"}, int'(bus.m_valid), 0);
        chk({name, "_m_last"}, int'(bus.m_last), 0);
        chk({name, "_m_data"}, int'(bus.m_data), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bus.start = 1'b0;
        bus.len = '0;
        bus.m_ready = 1'b0;
        rst_l = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_l = 1'b1;
        tick();

        // Back-to-back burst of 4
        bus.m_ready = 1'b1;
        preload(1, 4);
        clear_stats();
        do_start(4);
        wait_done(60, 1'b0);
        check_beats("t1", 1, 4);
        chk("t1_reads", rden_cnt, 4);
        chk("t1_latency", first_valid_cyc - start_cyc, 3);
        if (beat_cyc.size() == 4) chk("t1_consecutive", beat_cyc[3] - beat_cyc[0], 3);
        else chk("t1_beat_cycles", beat_cyc.size(), 4);
        chk("t1_done_pulses", done_cnt, 1);

        // Zero-length burst
        clear_stats();
        do_start(0);
        wait_done(20, 1'b0);
        repeat (3) tick();
        chk("t2_reads", rden_cnt, 0);
        chk("t2_valid_seen", first_valid_cyc, -1);
        chk("t2_done_pulses", done_cnt, 1);

        // Back-pressure, ready toggling 1,0,1,0
        flush_fifo();
        preload(1, 8);
        clear_stats();
        bus.m_ready = 1'b1;
        do_start(5);
        wait_done(100, 1'b1);
        bus.m_ready = 1'b1;
        tick();
        check_beats("t3", 1, 5);
        chk("t3_reads", rden_cnt, 5);
        chk("t3_fifo_left", fq.size(), 3);

        // FIFO runs dry mid-burst and refills
        flush_fifo();
        preload(1, 2);
        clear_stats();
        do_start(4);
        repeat (6) tick();
        fq.push_back(8'd3);
        fq.push_back(8'd4);
        wait_done(80, 1'b0);
        check_beats("t4", 1, 4);
        chk("t4_reads", rden_cnt, 4);
        if (beat_cyc.size() == 4) chk("t4_gap", int'(beat_cyc[3] - beat_cyc[0] > 3), 1);

        // Start while busy is ignored
        flush_fifo();
        preload(1, 12);
        clear_stats();
        do_start(3);
        do_start(9);
        wait_done(60, 1'b0);
        repeat (5) tick();
        check_beats("t5", 1, 3);
        chk("t5_reads", rden_cnt, 3);
        chk("t5_fifo_left", fq.size(), 9);
        chk("t5_done_pulses", done_cnt, 1);

        // Reset mid-burst, then a fresh burst
        flush_fifo();
        preload(10, 6);
        clear_stats();
        do_start(6);
        begin
            int i;
            for (i = 0; i < 60; i++) begin
                @(posedge clk);
                if (beats.size() >= 2) break;
            end
            chk("t6_two_beats_within_budget", int'(beats.size() >= 2), 1);
        end
        #2 rst_l = 1'b0;
        #1 check_outputs_zero("t6_reset");
        tick();
        rst_l = 1'b1;
        flush_fifo();
        preload(21, 2);
        clear_stats();
        do_start(2);
        wait_done(40, 1'b0);
        check_beats("t6_after", 21, 2);
        chk("t6_reads", rden_cnt, 2);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
